// File: rtl/tky_unload_32b.sv
// 128-bit tweakey/state/tag unloader: captures a full word in one cycle and
// streams it out as 32-bit words on a valid/ready bus, mirroring the pdi load chain.
module tky_unload_32b #(
  parameter bit MSW_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [127:0] din,
  input  logic [2:0]   nwords,
  output logic [31:0]  pdo,
  output logic         pdo_valid,
  input  logic         pdo_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [127:0]   sr_q, sr_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           xfer, last;
  logic [2:0]     nw_clamped;

  assign nw_clamped = (nwords == 3'd0 || nwords > 3'd4) ? 3'd4 : nwords;
  assign xfer       = (state_q == SEND) && pdo_ready;
  assign last       = xfer && (cnt_q == 3'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; clr overrides everything including a final transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld)   state_d = SEND;
      SEND:    if (last) state_d = IDLE;
      default:           state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // Datapath next-state: shift toward the output end with zero fill
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (state_q == IDLE && ld) begin
      sr_d  = din;
      cnt_d = nw_clamped;
    end else if (xfer) begin
      sr_d   = MSW_FIRST ? {sr_q[95:0], 32'h0} : {32'h0, sr_q[127:32]};
      cnt_d  = cnt_q - 3'd1;
      done_d = (cnt_q == 3'd1);
    end
    if (clr) begin
      sr_d   = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Outputs depend only on registered state, so pdo_ready never reaches them
  always_comb begin
    pdo_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    done      = done_q;
    pdo       = '0;
    if (state_q == SEND) pdo = MSW_FIRST ? sr_q[127:96] : sr_q[31:0];
  end

endmodule

// File: tb/tb_tky_unload_32b.sv
// Directed bench for tky_unload_32b: table of streams plus hand-written corner sequences,
// run against an MSW-first and an LSW-first instance sharing the same inputs.
module tb_tky_unload_32b;

  logic         clk = 1'b0;
  logic         rst, clr, ld, pdo_ready;
  logic [127:0] din;
  logic [2:0]   nwords;
  logic [31:0]  pdo_m, pdo_l;
  logic         pdo_valid_m, pdo_valid_l, busy_m, busy_l, done_m, done_l;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  tky_unload_32b #(.MSW_FIRST(1'b1)) u_msw (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .nwords(nwords),
    .pdo(pdo_m), .pdo_valid(pdo_valid_m), .pdo_ready(pdo_ready),
    .busy(busy_m), .done(done_m));

  tky_unload_32b #(.MSW_FIRST(1'b0)) u_lsw (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .din(din), .nwords(nwords),
    .pdo(pdo_l), .pdo_valid(pdo_valid_l), .pdo_ready(pdo_ready),
    .busy(busy_l), .done(done_l));

  typedef struct {
    logic [127:0] din;
    logic [2:0]   nw;
    logic [15:0]  rpat;     // bit k = pdo_ready in stream cycle k+1
    int           expn;
    int           expdone;  // cycle (after ld) in which done pulses
    logic [31:0]  expm [4];
    logic [31:0]  expl [4];
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] wm [4];
  logic [31:0] wl [4];
  int          nacc, ndone, done_cyc, held;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; records accepted words and done timing
  task automatic stream(input logic [127:0] d, input logic [2:0] nw, input logic [15:0] rpat);
    logic        stalled;
    logic [31:0] prev;
    nacc = 0; ndone = 0; done_cyc = 0; held = 0; stalled = 1'b0; prev = '0;
    din = d; nwords = nw; ld = 1'b1; pdo_ready = 1'b0;
    @(negedge clk);
    ld = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      pdo_ready = (c <= 16) ? rpat[c-1] : 1'b1;
      if (done_m) begin
        ndone++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (pdo_valid_l !== pdo_valid_m) held++;
      if (pdo_valid_m) begin
        if (stalled && pdo_m !== prev) held++;
        if (pdo_ready) begin
          if (nacc < 4) begin
            wm[nacc] = pdo_m;
            wl[nacc] = pdo_l;
          end
          nacc++;
        end
        stalled = !pdo_ready;
        prev    = pdo_m;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
    end
    pdo_ready = 1'b0;
  endtask

  localparam logic [127:0] D = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] E = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  initial begin
    logic [31:0]  rw [4];
    logic [127:0] lreg;

    vecs[0].din = D; vecs[0].nw = 3'd4; vecs[0].rpat = 16'hFFFF; vecs[0].expn = 4; vecs[0].expdone = 5;
    vecs[0].expm = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    vecs[0].expl = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    vecs[1] = vecs[0]; vecs[1].rpat = 16'hFF74; vecs[1].expdone = 8;
    vecs[2] = vecs[0]; vecs[2].nw = 3'd2; vecs[2].expn = 2; vecs[2].expdone = 3;
    vecs[3] = vecs[0]; vecs[3].nw = 3'd0;
    vecs[4].din = E; vecs[4].nw = 3'd1; vecs[4].rpat = 16'hFFFF; vecs[4].expn = 1; vecs[4].expdone = 2;
    vecs[4].expm = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    vecs[4].expl = '{32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
    vecs[5] = vecs[4]; vecs[5].nw = 3'd7; vecs[5].rpat = 16'hFFF9; vecs[5].expn = 4; vecs[5].expdone = 7;

    rst = 1'b1; clr = 1'b0; ld = 1'b0; pdo_ready = 1'b0; din = '0; nwords = '0;
    #12;
    chk("reset_pdo", pdo_m, 0);
    chk("reset_valid", pdo_valid_m, 0);
    chk("reset_busy", busy_m, 0);
    chk("reset_done", done_m, 0);
    rst = 1'b0;
    @(negedge clk);

    // pdo_ready while idle does nothing
    pdo_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_valid", pdo_valid_m, 0);
    chk("idle_ready_done", done_m, 0);
    pdo_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      stream(vecs[i].din, vecs[i].nw, vecs[i].rpat);
      chk($sformatf("v%0d_count", i), nacc, vecs[i].expn);
      chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].expdone);
      chk($sformatf("v%0d_done_once", i), ndone, 1);
      chk($sformatf("v%0d_held", i), held, 0);
      for (int k = 0; k < vecs[i].expn; k++) begin
        chk($sformatf("v%0d_msw_w%0d", i, k), wm[k], vecs[i].expm[k]);
        chk($sformatf("v%0d_lsw_w%0d", i, k), wl[k], vecs[i].expl[k]);
      end
    end

    // ld while busy ignored; ld in done cycle starts the next stream
    din = D; nwords = 3'd4; ld = 1'b1; pdo_ready = 1'b1;
    @(negedge clk);
    din = E; nwords = 3'd1;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("busy_ld_w%0d", c), pdo_m, D[127-32*(c-1) -: 32]);
      chk($sformatf("busy_ld_busy%0d", c), busy_m, 1);
      @(negedge clk);
    end
    chk("done_ld_done", done_m, 1);
    chk("done_ld_busy", busy_m, 0);
    @(negedge clk);
    ld = 1'b0;
    chk("done_ld_valid", pdo_valid_m, 1);
    chk("done_ld_word", pdo_m, 32'hDEADBEEF);
    @(negedge clk);
    chk("done_ld_done2", done_m, 1);
    pdo_ready = 1'b0;
    @(negedge clk);

    // async reset after word 2
    din = D; nwords = 3'd4; ld = 1'b1; pdo_ready = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_word3", pdo_m, 32'h8899AABB);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_pdo", pdo_m, 0);
    chk("rst_async_valid", pdo_valid_m, 0);
    chk("rst_async_busy", busy_m, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_valid", pdo_valid_m, 0);

    // clr after word 1
    din = D; nwords = 3'd4; ld = 1'b1; pdo_ready = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_valid", pdo_valid_m, 0);
    chk("clr_busy", busy_m, 0);
    chk("clr_pdo", pdo_m, 0);
    chk("clr_done", done_m, 0);

    // clr coinciding with final transfer suppresses done
    din = E; nwords = 3'd1; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_last_done", done_m, 0);
    chk("clr_last_valid", pdo_valid_m, 0);
    pdo_ready = 1'b0;
    @(negedge clk);

    // round trip through a model of the 32-bit pdi load chain
    lreg = '0;
    for (int k = 0; k < 4; k++) begin
      rw[k] = $urandom;
      lreg  = {lreg[95:0], rw[k]};
    end
    stream(lreg, 3'd4, 16'hFFFF);
    chk("rt_count", nacc, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("rt_w%0d", k), wm[k], rw[k]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
